// File: rtl/latch_window_pkg.sv
// Shared types and helpers for the windowed latch bank: the per-channel state
// encoding and a saturating increment used by the change counters.
package latch_window_pkg;

    typedef enum logic {
        HOLD = 1'b0,
        OPEN = 1'b1
    } win_state_t;

    // Increment value, sticking at the all-ones pattern of a width-bit field.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/latch_window_chan.sv
// One windowed holding register: captures d for a programmable number of
// clock edges after a start pulse, then holds, counting in-window changes.
module latch_window_chan
    import latch_window_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             transparent,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             open,
    output logic             done,
    output logic [WIN_W-1:0] changes
);

    win_state_t       state;
    logic [WIN_W-1:0] cnt;
    logic [WIN_W-1:0] eff_len;
    logic             differs;

    // A zero-length request still captures once.
    always_comb begin
        eff_len = (win_len == '0) ? WIN_W'(1) : win_len;
        differs = (d != q);
    end

    // cnt holds the capture edges still owed after the current one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= HOLD;
            cnt     <= '0;
            q       <= '0;
            open    <= 1'b0;
            done    <= 1'b0;
            changes <= '0;
        end else if (start) begin
            q       <= d;
            cnt     <= eff_len - WIN_W'(1);
            changes <= differs ? WIN_W'(1) : '0;
            if (eff_len > WIN_W'(1)) begin
                state <= OPEN;
                open  <= 1'b1;
                done  <= 1'b0;
            end else begin
                state <= HOLD;
                open  <= 1'b0;
                done  <= 1'b1;
            end
        end else begin
            case (state)
                OPEN: begin
                    q   <= d;
                    cnt <= cnt - WIN_W'(1);
                    if (differs) begin
                        changes <= WIN_W'(sat_inc(32'(changes), WIN_W));
                    end
                    if (cnt == WIN_W'(1)) begin
                        state <= HOLD;
                        open  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                    end
                end
                default: begin
                    done <= 1'b0;
                    open <= 1'b0;
                    // The override refreshes q but never touches the window bookkeeping.
                    if (transparent) begin
                        q <= d;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/latch_window_bank.sv
// Bank of independent windowed holding registers; slices the packed data
// buses per channel and broadcasts the shared window length and override.
module latch_window_bank
    import latch_window_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int WIN_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       start,
    input  logic [WIN_W-1:0]          win_len,
    input  logic                      transparent,
    input  logic [CHANNELS*WIDTH-1:0] d,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       open,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS*WIN_W-1:0] changes
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        latch_window_chan #(
            .WIDTH (WIDTH),
            .WIN_W (WIN_W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .start       (start[i]),
            .win_len     (win_len),
            .transparent (transparent),
            .d           (d[i*WIDTH +: WIDTH]),
            .q           (q[i*WIDTH +: WIDTH]),
            .open        (open[i]),
            .done        (done[i]),
            .changes     (changes[i*WIN_W +: WIN_W])
        );
    end

endmodule

// File: tb/tb_latch_window_bank.sv
// Directed bench for latch_window_bank: a remaining-edges model per channel is
// compared every cycle, with literal expectations at the key points.
module tb_latch_window_bank;

    logic        clk;
    logic        rst;
    logic [3:0]  start;
    logic [7:0]  win_len;
    logic        transparent;
    logic [31:0] d;
    logic [31:0] q;
    logic [3:0]  open;
    logic [3:0]  done;
    logic [31:0] changes;

    int n_vec;
    int n_miss;
    bit check_en;

    logic [7:0] m_q   [4];
    logic [7:0] m_chg [4];
    int         m_rem [4];
    bit         m_done[4];
    int         m_len;

    latch_window_bank #(.WIDTH(8), .CHANNELS(4), .WIN_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .win_len     (win_len),
        .transparent (transparent),
        .d           (d),
        .q           (q),
        .open        (open),
        .done        (done),
        .changes     (changes)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] st, input logic [7:0] wl,
                                 input logic tr, input logic [31:0] dv);
        @(negedge clk);
        #1;
        start       = st;
        win_len     = wl;
        transparent = tr;
        d           = dv;
    endtask

    // Model: a window is a count of capture edges still owed; q follows d on
    // every owed edge, and done marks the edge that used up the last one.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_q[i] = '0; m_chg[i] = '0; m_rem[i] = 0; m_done[i] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_len = (win_len == 8'd0) ? 1 : int'(win_len);
                if (start[i]) begin
                    m_rem[i] = m_len;
                    m_chg[i] = '0;
                end
                if (m_rem[i] > 0) begin
                    if (d[i*8 +: 8] != m_q[i] && m_chg[i] != 8'hFF) m_chg[i] = m_chg[i] + 8'd1;
                    m_q[i]    = d[i*8 +: 8];
                    m_rem[i]  = m_rem[i] - 1;
                    m_done[i] = (m_rem[i] == 0);
                end else begin
                    m_done[i] = 0;
                    if (transparent) m_q[i] = d[i*8 +: 8];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en && !rst) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("q%0d", i), 32'(q[i*8 +: 8]), 32'(m_q[i]));
                checkOutput($sformatf("open%0d", i), 32'(open[i]), 32'(m_rem[i] > 0));
                checkOutput($sformatf("done%0d", i), 32'(done[i]), 32'(m_done[i]));
                checkOutput($sformatf("changes%0d", i), 32'(changes[i*8 +: 8]), 32'(m_chg[i]));
            end
        end
    end

    initial begin
        n_vec = 0; n_miss = 0; check_en = 0;
        rst = 1'b1; start = '0; win_len = '0; transparent = 1'b0; d = '0;
        #11;
        checkOutput("reset q", q, 32'h0);
        checkOutput("reset open", 32'(open), 32'h0);
        checkOutput("reset done", 32'(done), 32'h0);
        checkOutput("reset changes", changes, 32'h0);
        #1 rst = 1'b0;
        check_en = 1;

        // Idle: data toggles without start, q must stay cleared.
        applyStimulus(4'b0000, 8'd3, 1'b0, 32'hFFFF_FFFF);
        applyStimulus(4'b0000, 8'd3, 1'b0, 32'h1234_5678);
        @(posedge clk); #1;
        checkOutput("idle q", q, 32'h0);

        // Basic three-edge window on channel 0.
        applyStimulus(4'b0001, 8'd3, 1'b0, 32'h0000_00A5);
        @(posedge clk); #1;
        checkOutput("basic q0 k", 32'(q[7:0]), 32'hA5);
        checkOutput("basic open0 k", 32'(open[0]), 32'h1);
        checkOutput("basic changes0 k", 32'(changes[7:0]), 32'h1);
        applyStimulus(4'b0000, 8'd3, 1'b0, 32'h0000_00A5);
        applyStimulus(4'b0000, 8'd3, 1'b0, 32'h0000_005A);
        @(posedge clk); #1;
        checkOutput("basic q0 k+2", 32'(q[7:0]), 32'h5A);
        checkOutput("basic open0 k+2", 32'(open[0]), 32'h0);
        checkOutput("basic done0 k+2", 32'(done[0]), 32'h1);
        checkOutput("basic changes0 k+2", 32'(changes[7:0]), 32'h2);
        applyStimulus(4'b0000, 8'd3, 1'b0, 32'h0000_00FF);
        @(posedge clk); #1;
        checkOutput("basic done0 k+3", 32'(done[0]), 32'h0);
        checkOutput("basic q0 k+3", 32'(q[7:0]), 32'h5A);

        // Zero and one length windows on channels 1 and 2.
        applyStimulus(4'b0010, 8'd0, 1'b0, 32'h0000_115A);
        @(posedge clk); #1;
        checkOutput("len0 q1", 32'(q[15:8]), 32'h11);
        checkOutput("len0 open1", 32'(open[1]), 32'h0);
        checkOutput("len0 done1", 32'(done[1]), 32'h1);
        applyStimulus(4'b0100, 8'd1, 1'b0, 32'h0022_005A);
        @(posedge clk); #1;
        checkOutput("len0 done1 after", 32'(done[1]), 32'h0);
        checkOutput("len1 q2", 32'(q[23:16]), 32'h22);
        checkOutput("len1 done2", 32'(done[2]), 32'h1);
        checkOutput("len1 open2", 32'(open[2]), 32'h0);
        applyStimulus(4'b0000, 8'd1, 1'b0, 32'h0099_995A);

        // Retrigger on channel 3, plus a mid-window length change that must be ignored.
        applyStimulus(4'b1000, 8'd4, 1'b0, 32'h0100_0000);
        applyStimulus(4'b0000, 8'd4, 1'b0, 32'h0200_0000);
        applyStimulus(4'b1000, 8'd4, 1'b0, 32'h0300_0000);
        applyStimulus(4'b0000, 8'd9, 1'b0, 32'h0400_0000);
        applyStimulus(4'b0000, 8'd9, 1'b0, 32'h0500_0000);
        applyStimulus(4'b0000, 8'd9, 1'b0, 32'h0600_0000);
        @(posedge clk); #1;
        checkOutput("retrig q3", 32'(q[31:24]), 32'h06);
        checkOutput("retrig done3", 32'(done[3]), 32'h1);
        checkOutput("retrig changes3", 32'(changes[31:24]), 32'h4);
        applyStimulus(4'b0000, 8'd9, 1'b0, 32'h0700_0000);

        // Global transparent override, then release.
        applyStimulus(4'b0000, 8'd2, 1'b1, 32'h3132_3334);
        applyStimulus(4'b0000, 8'd2, 1'b1, 32'h4142_4344);
        applyStimulus(4'b0000, 8'd2, 1'b1, 32'h5152_5354);
        @(posedge clk); #1;
        checkOutput("transp q", q, 32'h5152_5354);
        checkOutput("transp done", 32'(done), 32'h0);
        applyStimulus(4'b0000, 8'd2, 1'b0, 32'h6162_6364);
        @(posedge clk); #1;
        checkOutput("transp release q", q, 32'h5152_5354);

        // Simultaneous starts, then async reset mid-window.
        applyStimulus(4'b1111, 8'd5, 1'b0, 32'hD4C3_B2A1);
        @(posedge clk); #1;
        checkOutput("multi q", q, 32'hD4C3_B2A1);
        checkOutput("multi open", 32'(open), 32'hF);
        applyStimulus(4'b0000, 8'd5, 1'b0, 32'h0102_0304);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checkOutput("async q", q, 32'h0);
        checkOutput("async open", 32'(open), 32'h0);
        checkOutput("async done", 32'(done), 32'h0);
        checkOutput("async changes", changes, 32'h0);
        @(negedge clk); #2;
        rst = 1'b0;
        applyStimulus(4'b0000, 8'd5, 1'b0, 32'hEEEE_EEEE);
        applyStimulus(4'b0000, 8'd5, 1'b0, 32'h7777_7777);
        @(posedge clk); #1;
        checkOutput("post reset q", q, 32'h0);
        @(negedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/latch_window_bank.md
# latch_window_bank

Parametrised multi-channel successor to the single transparent latch: CHANNELS independent WIDTH-bit holding registers, each transparent only for a programmable window of clock edges after a start pulse, then frozen. The block adds retrigger, a global transparent override, end-of-window pulses and per-channel change counting. It sits between asynchronous-ish sample sources and downstream logic that needs values held stable between capture windows.

## Interface
- WIDTH, 8, data bits per channel
- CHANNELS, 4, number of independent channels
- WIN_W, 8, width of window length and change counters
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- start  in  CHANNELS  per-channel window start/retrigger, sampled at clk edge
- win_len  in  WIN_W  window length in edges, shared, sampled at each start edge
- transparent  in  1  global override: all q follow d every edge
- d  in  CHANNELS*WIDTH  channel data, channel i at [i*WIDTH +: WIDTH]
- q  out  CHANNELS*WIDTH  held/captured data
- open  out  CHANNELS  channel is in OPEN state
- done  out  CHANNELS  one-cycle pulse after last capture edge of a window
- changes  out  CHANNELS*WIN_W  count of capture edges where d differed from q, channel i at [i*WIN_W +: WIN_W]

## Operation
- Per-channel FSM, states HOLD and OPEN; reset state HOLD.
- Effective length L = win_len, with win_len==0 treated as L=1.
- Edge with start[i]=1 (any state): q_i<=d_i; cnt<=L-1; changes_i<=(d_i!=q_i)?1:0; next state OPEN if L>1, else HOLD with done_i<=1.
- Edge in OPEN, start[i]=0: q_i<=d_i; cnt<=cnt-1; changes_i increments if d_i!=q_i, saturating at all-ones; if cnt==1 then HOLD and done_i<=1.
- Retrigger: start in OPEN reloads cnt from current win_len, clears and restarts changes; no done pulse for the abandoned window.
- HOLD, start=0: q_i, changes_i unchanged; done_i<=0.
- transparent=1: q_i<=d_i on every edge for all channels; FSM, cnt, done and changes behave exactly as with transparent=0 (changes counts only in-window edges).
- Channels fully independent; simultaneous starts on several channels all honoured.

## Timing
- Reset (async assert, any time, incl. mid-window): q=0, open=0, done=0, changes=0, cnt=0, state HOLD; takes effect immediately, no clock needed.
- Start at edge k: exactly L capture edges, k..k+L-1; open high from after edge k through edge k+L-1 (L-1 cycles; 0 cycles if L=1).
- done high for one cycle following edge k+L-1; open and done never both high.
- q is a registered output: d changes between edges never propagate combinationally.
- win_len changes mid-window have no effect until next start.

## Structure
- Package latch_window_pkg: state enum typedef (HOLD, OPEN), saturating-increment function.
- Sub-module latch_window_chan (one channel: FSM, cnt, q, changes), generated CHANNELS times by the top; top does only slicing and broadcasting of win_len/transparent.

## Test plan
- Reset then idle: rst pulse mid-cycle -> q=0, open=0, done=0, changes=0 immediately; d toggling without start leaves q=0.
- Basic window ch0: win_len=3, d0=8'hA5, start0 at edge k, d0=8'h5A before k+2 -> q0=A5 after k, 5A after k+2, open0 high 2 cycles, done0 pulse after k+2, changes0=2 (from q=0).
- win_len=0 and 1: start -> single capture, open never high, done pulse next cycle.
- Retrigger: win_len=4, start at k and k+2 -> captures through k+5, single done after k+5, changes counts from k+2.
- Transparent override: transparent=1, no start -> q tracks d every edge, done=0, changes=0; release holds last value.
- Async reset at edge k+1 of a 5-edge window, plus simultaneous starts on all 4 channels -> all outputs 0, HOLD; channels otherwise independent with distinct d values.
